controller_sequencer: RTL
=========================

// Module: controller_sequencer
// PURPOSE
//   SAP-1 control unit. A one-hot ring counter steps through T-states T1..T6 and
//   decodes the instruction-register opcode into the 12-bit control word that drives
//   the program counter (Cp, Ep), MAR, RAM, IR, accumulator, adder/subtracter, B and
//   output registers. Also owns the sticky halt flag that gates the system clock.
// PARAMETERS
//   SHORT_CYCLE  0  1: return to T1 right after the last non-NOP T-state of the opcode
//   OP_LDA  4'h0   opcode: load accumulator from RAM[addr]
//   OP_ADD  4'h1   opcode: A <= A + RAM[addr]
//   OP_SUB  4'h2   opcode: A <= A - RAM[addr]
//   OP_OUT  4'hE   opcode: output register <= A
//   OP_HLT  4'hF   opcode: halt
// PORTS
//   CLK_bar  in   1   inverted system clock; all state changes on its rising edge
//   CLR_bar  in   1   asynchronous active-low clear
//   opcode   in   4   IR upper nibble, valid from T4 onward
//   CON      out  12  {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
//   T        out  6   one-hot ring state, T[0]=T1 .. T[5]=T6
//   HLT_bar  out  1   low = halted; clock generator stops CLK while low
// BEHAVIOUR
//   - Reset (CLR_bar low, async): T=6'b000001, halted=0 so HLT_bar=1; CON follows decode (T1 -> 12'h5E3).
//   - Ring: each rising CLK_bar edge rotates T left; T6 -> T1. Exactly one bit set always.
//   - CON is combinational from T and opcode, glitch-free w.r.t. a stable opcode.
//   - NOP word 12'h3E3 (all loads inactive, all enables off).
//   - Fetch, all opcodes: T1 12'h5E3 (Ep, Lm_bar=0); T2 12'hBE3 (Cp);
//     T3 12'h263 (CE_bar=0, Li_bar=0).
//   - LDA: T4 12'h1A3 (Lm_bar=0, Ei_bar=0); T5 12'h2C3 (CE_bar=0, La_bar=0); T6 NOP.
//   - ADD: T4 12'h1A3; T5 12'h2E1 (CE_bar=0, Lb_bar=0); T6 12'h3C7 (La_bar=0, Eu).
//   - SUB: as ADD but T6 12'h3CF (La_bar=0, Su, Eu).
//   - OUT: T4 12'h3F2 (Ea, Lo_bar=0); T5, T6 NOP.
//   - HLT: T4 NOP; on the rising edge ending T4, halted<=1, HLT_bar->0.
//   - Undefined opcodes: T4..T6 NOP, cycle completes normally.
//   - Halted: T frozen at T4, CON=NOP regardless of edges/opcode; only CLR_bar exits.
//   - SHORT_CYCLE=1: next state T1 after T5 for LDA, after T4 for OUT and undefined;
//     ADD/SUB unchanged. SHORT_CYCLE=0: always full six states.
//   - Cp asserted in exactly one T-state per instruction: PC +1 per instruction.
//   - CLR_bar mid-cycle: immediate return to T1, halt cleared; deassert resumes at T1.
// TESTING
//   - Reset then 6 edges, opcode=OP_LDA: CON = 5E3,BE3,263,1A3,2C3,3E3; T back to 000001.
//   - opcode=OP_SUB across T4..T6: CON 1A3, 2E1, 3CF; OP_ADD: T6 gives 3C7.
//   - opcode=OP_HLT: HLT_bar low after T4 edge; 10 more edges: T=001000, CON=3E3.
//     CLR_bar pulse: HLT_bar=1, T=000001.
//   - SHORT_CYCLE=1, OP_OUT: T1..T4 then T1 (4-state cycle); OP_LDA 5-state cycle.
//   - CLR_bar low asynchronously during T5 of ADD: T=000001, CON=5E3 without a clock edge.
//   - Opcode 4'h7: T4..T6 all 3E3; Cp high only in T2 across 3 back-to-back instructions.

Source files
------------

// File: rtl/controller_sequencer.sv
// SAP-1 control unit.
// A one-hot ring counter walks the T-states T1..T6 while the instruction
// register opcode is decoded into the 12-bit control word that drives the
// program counter, MAR, RAM, IR, accumulator, adder/subtracter, B and output
// registers. The block also owns the sticky halt flag that gates the clock.
//
// Control word bit order (MSB first):
//   {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
module controller_sequencer #(
   parameter bit         SHORT_CYCLE = 1'b0,
   parameter logic [3:0] OP_LDA      = 4'h0,
   parameter logic [3:0] OP_ADD      = 4'h1,
   parameter logic [3:0] OP_SUB      = 4'h2,
   parameter logic [3:0] OP_OUT      = 4'hE,
   parameter logic [3:0] OP_HLT      = 4'hF
) (
   input  logic        CLK_bar,
   input  logic        CLR_bar,
   input  logic [3:0]  opcode,
   output logic [11:0] CON,
   output logic [5:0]  T,
   output logic        HLT_bar
);

   // Control words. Active-low loads/enables sit at 1 when idle, so the
   // "do nothing" word is not zero.
   localparam logic [11:0] CON_NOP      = 12'h3E3;
   localparam logic [11:0] CON_FETCH_T1 = 12'h5E3;
   localparam logic [11:0] CON_FETCH_T2 = 12'hBE3;
   localparam logic [11:0] CON_FETCH_T3 = 12'h263;
   localparam logic [11:0] CON_ADDR_T4  = 12'h1A3;
   localparam logic [11:0] CON_LDA_T5   = 12'h2C3;
   localparam logic [11:0] CON_ARITH_T5 = 12'h2E1;
   localparam logic [11:0] CON_ADD_T6   = 12'h3C7;
   localparam logic [11:0] CON_SUB_T6   = 12'h3CF;
   localparam logic [11:0] CON_OUT_T4   = 12'h3F2;

   // One-hot ring encoding: the state value is the T output directly.
   typedef enum logic [5:0] {
      T1_S = 6'b000001,
      T2_S = 6'b000010,
      T3_S = 6'b000100,
      T4_S = 6'b001000,
      T5_S = 6'b010000,
      T6_S = 6'b100000
   } t_state_e;

   t_state_e state;
   logic     halted;

   logic is_lda;
   logic is_add;
   logic is_sub;
   logic is_out;
   logic is_hlt;
   logic is_undef;
   logic end_after_t4;
   logic end_after_t5;

   // Opcode classification shared by the ring sequencing and the decoder.
   always_comb begin
      is_lda   = (opcode == OP_LDA);
      is_add   = (opcode == OP_ADD);
      is_sub   = (opcode == OP_SUB);
      is_out   = (opcode == OP_OUT);
      is_hlt   = (opcode == OP_HLT);
      is_undef = !(is_lda || is_add || is_sub || is_out || is_hlt);
   end

   // With short cycles enabled an instruction leaves the ring as soon as its
   // last useful T-state is done; ADD/SUB need all six states anyway.
   always_comb begin
      end_after_t4 = SHORT_CYCLE && (is_out || is_undef);
      end_after_t5 = SHORT_CYCLE && is_lda;
   end

   // Ring counter and sticky halt flag. Once halted the ring stays parked at
   // T4 whatever the clock does; only the clear brings the machine back.
   always_ff @(posedge CLK_bar or negedge CLR_bar) begin
      if (!CLR_bar) begin
         state  <= T1_S;
         halted <= 1'b0;
      end else if (halted) begin
         state  <= T4_S;
         halted <= 1'b1;
      end else begin
         case (state)
            T1_S: state <= T2_S;
            T2_S: state <= T3_S;
            T3_S: state <= T4_S;
            T4_S: begin
               if (is_hlt) begin
                  halted <= 1'b1;
                  state  <= T4_S;
               end else if (end_after_t4) begin
                  state <= T1_S;
               end else begin
                  state <= T5_S;
               end
            end
            T5_S: state <= end_after_t5 ? T1_S : T6_S;
            T6_S: state <= T1_S;
            default: state <= T1_S;
         endcase
      end
   end

   assign T       = state;
   assign HLT_bar = ~halted;

   // Control word decode: fetch states are common to every opcode, the
   // execute states depend on the opcode, and a halted machine issues NOPs.
   always_comb begin
      CON = CON_NOP;
      if (!halted) begin
         case (state)
            T1_S: CON = CON_FETCH_T1;
            T2_S: CON = CON_FETCH_T2;
            T3_S: CON = CON_FETCH_T3;
            T4_S: begin
               if (is_lda || is_add || is_sub) begin
                  CON = CON_ADDR_T4;
               end else if (is_out) begin
                  CON = CON_OUT_T4;
               end else begin
                  CON = CON_NOP;
               end
            end
            T5_S: begin
               if (is_lda) begin
                  CON = CON_LDA_T5;
               end else if (is_add || is_sub) begin
                  CON = CON_ARITH_T5;
               end else begin
                  CON = CON_NOP;
               end
            end
            T6_S: begin
               if (is_add) begin
                  CON = CON_ADD_T6;
               end else if (is_sub) begin
                  CON = CON_SUB_T6;
               end else begin
                  CON = CON_NOP;
               end
            end
            default: CON = CON_NOP;
         endcase
      end
   end

endmodule
